mantissa_normalizer: RTL and testbench

//  Stage directly upstream of the posit rounding stage. Takes the raw 64-bit significand product and its

---
 rtl/norm_pkg.sv | 7 +
 rtl/lod64.sv | 19 +
 rtl/mantissa_normalizer.sv | 134 +++++++++++++
 tb/tb_mantissa_normalizer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and constants for the posit mantissa normalizer.
package norm_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, ADJUST} state_t;
    localparam int MANT_W     = 64;
    localparam int HIDDEN_BIT = 62;
    localparam int K_W        = 6;
endpackage

// File: rtl/lod64.sv
// 64-bit leading-one detector: position of the highest set bit plus a valid flag.
module lod64
    import norm_pkg::*;
(
    input  logic [MANT_W-1:0] vec,
    output logic [5:0]        pos,
    output logic              valid
);
    always_comb begin
        pos   = '0;
        valid = 1'b0;
        for (int i = 0; i < MANT_W; i++) begin
            if (vec[i]) begin
                pos   = 6'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mantissa_normalizer.sv
// Normalises a 64-bit significand so the hidden one sits at bit 62 and splits the scale into regime k / exponent.
// Define FAST_LOD_EN for a single-cycle SHIFT state (leading-one detector + barrel shift); otherwise one bit per cycle.
module mantissa_normalizer
    import norm_pkg::*;
#(
    parameter int ES      = 2,
    parameter int SCALE_W = 10,
    parameter int KMAX    = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MANT_W-1:0]         raw_mantissa,
    input  logic signed [SCALE_W-1:0] scale_in,
    output logic [MANT_W-1:0]         shifted_mantissa,
    output logic [K_W-1:0]            k_out,
    output logic [ES-1:0]             exp_out,
    output logic                      zero_flag,
    output logic                      sat_flag,
    output logic                      busy,
    output logic                      done
);
    // One extra bit so the scale survives a full 62-place left normalisation.
    localparam int S_W = SCALE_W + 1;
    localparam logic signed [S_W-1:0] KMAX_S = S_W'(KMAX);
    localparam logic [K_W-1:0]        K_POS  = K_W'(KMAX);
    localparam logic [K_W-1:0]        K_NEG  = K_W'(-KMAX);

    state_t                  state;
    logic [MANT_W-1:0]       m;
    logic signed [S_W-1:0]   s;
    logic signed [S_W-1:0]   k_full;

    assign k_full = s >>> ES;

`ifdef FAST_LOD_EN
    logic [5:0] lod_pos;
    logic       lod_valid;
    logic [5:0] shamt;

    lod64 u_lod64 (
        .vec   (m),
        .pos   (lod_pos),
        .valid (lod_valid)
    );

    assign shamt = 6'(HIDDEN_BIT) - lod_pos;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            m                <= '0;
            s                <= '0;
            shifted_mantissa <= '0;
            k_out            <= '0;
            exp_out          <= '0;
            zero_flag        <= 1'b0;
            sat_flag         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= raw_mantissa;
                        s     <= {scale_in[SCALE_W-1], scale_in};
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef FAST_LOD_EN
                    if (!lod_valid) begin
                        state <= ADJUST;
                    end else if (m[MANT_W-1]) begin
                        m     <= m >> 1;
                        s     <= s + S_W'(1);
                        state <= ADJUST;
                    end else begin
                        m     <= m << shamt;
                        s     <= s - S_W'(shamt);
                        state <= ADJUST;
                    end
`else
                    if (m == '0) begin
                        state <= ADJUST;
                    end else if (m[MANT_W-1]) begin
                        m     <= m >> 1;
                        s     <= s + S_W'(1);
                        state <= ADJUST;
                    end else if (m[HIDDEN_BIT]) begin
                        state <= ADJUST;
                    end else begin
                        m <= m << 1;
                        s <= s - S_W'(1);
                    end
`endif
                end
                ADJUST: begin
                    if (m == '0) begin
                        shifted_mantissa <= '0;
                        k_out            <= '0;
                        exp_out          <= '0;
                        zero_flag        <= 1'b1;
                        sat_flag         <= 1'b0;
                    end else begin
                        shifted_mantissa <= m;
                        exp_out          <= s[ES-1:0];
                        zero_flag        <= 1'b0;
                        if (k_full > KMAX_S) begin
                            k_out    <= K_POS;
                            sat_flag <= 1'b1;
                        end else if (k_full < -KMAX_S) begin
                            k_out    <= K_NEG;
                            sat_flag <= 1'b1;
                        end else begin
                            k_out    <= k_full[K_W-1:0];
                            sat_flag <= 1'b0;
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed self-checking bench for mantissa_normalizer (latencies follow FAST_LOD_EN if defined).
module tb_mantissa_normalizer;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [63:0]        raw_mantissa;
    logic signed [9:0]  scale_in;
    logic [63:0]        shifted_mantissa;
    logic [5:0]         k_out;
    logic [1:0]         exp_out;
    logic               zero_flag;
    logic               sat_flag;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FAST_LOD_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mantissa_normalizer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .raw_mantissa     (raw_mantissa),
        .scale_in         (scale_in),
        .shifted_mantissa (shifted_mantissa),
        .k_out            (k_out),
        .exp_out          (exp_out),
        .zero_flag        (zero_flag),
        .sat_flag         (sat_flag),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]       raw;
        logic signed [9:0] scale;
        logic [63:0]       sh;
        logic [5:0]        k;
        logic [1:0]        ex;
        logic              z;
        logic              sat;
        int                lat_iter;
    } vec_t;

    // Drives one request at a negedge and counts posedges (start edge = 1) until done is seen.
    task automatic run_op(input logic [63:0] raw, input logic signed [9:0] sc, output int lat);
        @(negedge clk);
        raw_mantissa = raw;
        scale_in     = sc;
        start        = 1'b1;
        lat          = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
        end while (!done && lat < 200);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        raw_mantissa = '0;
        scale_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (shifted_mantissa !== 64'h0) begin n_err++; $display("FAIL reset_shifted got=%h exp=0", shifted_mantissa); end
        n_cmp++; if (k_out !== 6'h0) begin n_err++; $display("FAIL reset_k got=%h exp=0", k_out); end
        n_cmp++; if (exp_out !== 2'h0) begin n_err++; $display("FAIL reset_exp got=%h exp=0", exp_out); end
        n_cmp++; if (zero_flag !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero_flag); end
        n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        vec_t v[12];
        int   lat;
        int   exp_lat;
        v[0]  = '{64'h4000_0000_0000_0000,    0, 64'h4000_0000_0000_0000, 6'h00, 2'd0, 1'b0, 1'b0, 3};
        v[1]  = '{64'hC000_0000_0000_0000,    5, 64'h6000_0000_0000_0000, 6'h01, 2'd2, 1'b0, 1'b0, 3};
        v[2]  = '{64'h1000_0000_0000_0000,    0, 64'h4000_0000_0000_0000, 6'h3F, 2'd2, 1'b0, 1'b0, 5};
        v[3]  = '{64'h0,                     17, 64'h0,                   6'h00, 2'd0, 1'b1, 1'b0, 3};
        v[4]  = '{64'h4000_0000_0000_0000,  200, 64'h4000_0000_0000_0000, 6'h1E, 2'd0, 1'b0, 1'b1, 3};
        v[5]  = '{64'h4000_0000_0000_0000, -200, 64'h4000_0000_0000_0000, 6'h22, 2'd0, 1'b0, 1'b1, 3};
        v[6]  = '{64'h1,                      0, 64'h4000_0000_0000_0000, 6'h30, 2'd2, 1'b0, 1'b0, 65};
        v[7]  = '{64'h8000_0000_0000_0000,   -3, 64'h4000_0000_0000_0000, 6'h3F, 2'd2, 1'b0, 1'b0, 3};
        v[8]  = '{64'h4000_0000_0000_0000,  123, 64'h4000_0000_0000_0000, 6'h1E, 2'd3, 1'b0, 1'b0, 3};
        v[9]  = '{64'h4000_0000_0000_0000, -120, 64'h4000_0000_0000_0000, 6'h22, 2'd0, 1'b0, 1'b0, 3};
        v[10] = '{64'h4000_0000_0000_0000,  124, 64'h4000_0000_0000_0000, 6'h1E, 2'd0, 1'b0, 1'b1, 3};
        v[11] = '{64'h0000_0001_2345_6789,  511, 64'h48D1_59E2_4000_0000, 6'h1E, 2'd1, 1'b0, 1'b1, 33};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].raw, v[i].scale, lat);
            exp_lat = FAST ? 3 : v[i].lat_iter;
            n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
            n_cmp++; if (shifted_mantissa !== v[i].sh) begin n_err++; $display("FAIL vec%0d_shifted got=%h exp=%h", i, shifted_mantissa, v[i].sh); end
            n_cmp++; if (k_out !== v[i].k) begin n_err++; $display("FAIL vec%0d_k got=%h exp=%h", i, k_out, v[i].k); end
            n_cmp++; if (exp_out !== v[i].ex) begin n_err++; $display("FAIL vec%0d_exp got=%0d exp=%0d", i, exp_out, v[i].ex); end
            n_cmp++; if (zero_flag !== v[i].z) begin n_err++; $display("FAIL vec%0d_zero got=%b exp=%b", i, zero_flag, v[i].z); end
            n_cmp++; if (sat_flag !== v[i].sat) begin n_err++; $display("FAIL vec%0d_sat got=%b exp=%b", i, sat_flag, v[i].sat); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL vec%0d_busy_at_done got=%b exp=0", i, busy); end
            @(posedge clk);
            #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(64'hC000_0000_0000_0000, 5, lat);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (shifted_mantissa !== 64'h6000_0000_0000_0000) begin n_err++; $display("FAIL hold_idle_shifted got=%h exp=6000000000000000", shifted_mantissa); end
        n_cmp++; if (k_out !== 6'h01) begin n_err++; $display("FAIL hold_idle_k got=%h exp=01", k_out); end
        @(negedge clk);
        raw_mantissa = 64'h4000_0000_0000_0000;
        scale_in     = -200;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy got=%b exp=1", busy); end
        @(posedge clk);
        #1;
        n_cmp++; if (k_out !== 6'h01 || sat_flag !== 1'b0) begin n_err++; $display("FAIL hold_busy_outputs got k=%h sat=%b exp k=01 sat=0", k_out, sat_flag); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b1 || k_out !== 6'h22 || sat_flag !== 1'b1) begin n_err++; $display("FAIL hold_update got done=%b k=%h sat=%b exp done=1 k=22 sat=1", done, k_out, sat_flag); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(64'h4000_0000_0000_0000, 200, lat);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        // Next request is issued at the negedge inside the done cycle.
        run_op(64'hC000_0000_0000_0000, 5, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
        n_cmp++; if (shifted_mantissa !== 64'h6000_0000_0000_0000 || k_out !== 6'h01 || exp_out !== 2'd2 || sat_flag !== 1'b0)
            begin n_err++; $display("FAIL b2b_result got sh=%h k=%h exp=%0d sat=%b exp sh=6000000000000000 k=01 exp=2 sat=0", shifted_mantissa, k_out, exp_out, sat_flag); end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        int first_lat = 0;
        @(negedge clk);
        raw_mantissa = 64'h1000_0000_0000_0000;
        scale_in     = 0;
        start        = 1'b1;
        @(negedge clk);
        raw_mantissa = 64'h4000_0000_0000_0000;
        scale_in     = 100;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (dones == 1) first_lat = c + 3;
            end
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        n_cmp++; if (first_lat !== (FAST ? 3 : 5)) begin n_err++; $display("FAIL busy_latency got=%0d exp=%0d", first_lat, FAST ? 3 : 5); end
        n_cmp++; if (shifted_mantissa !== 64'h4000_0000_0000_0000 || k_out !== 6'h3F || exp_out !== 2'd2 || sat_flag !== 1'b0)
            begin n_err++; $display("FAIL busy_result got sh=%h k=%h exp=%0d sat=%b exp sh=4000000000000000 k=3f exp=2 sat=0", shifted_mantissa, k_out, exp_out, sat_flag); end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        int pre = FAST ? 1 : 10;
        @(negedge clk);
        raw_mantissa = 64'h1;
        scale_in     = 0;
        start        = 1'b1;
        for (int c = 0; c < pre; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) dones++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (done) dones++;
        n_cmp++; if (busy !== 1'b0 || shifted_mantissa !== 64'h0 || k_out !== 6'h0 || exp_out !== 2'd0 || sat_flag !== 1'b0 || zero_flag !== 1'b0)
            begin n_err++; $display("FAIL midrst_outputs got busy=%b sh=%h k=%h exp=%0d sat=%b z=%b exp all 0", busy, shifted_mantissa, k_out, exp_out, sat_flag, zero_flag); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_start_while_busy();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
